// File: rtl/gomoku_game_engine.sv
// Gomoku game engine: cursor navigation, stone placement with a sequential
// win scan (one neighbour cell per cycle), draw detection and a bounded
// circular undo history. All outputs are registered.
//
// Button handshake: each button is a level input; an action fires on the
// cycle where the input is high and was low the cycle before. Rising edges
// seen while the win check runs (busy = 1) are discarded, not queued. At
// most one action is taken per cycle, chosen by priority
// undo > put > right > left > up > down.
module gomoku_game_engine #(
  parameter int N          = 10,
  parameter int WIN_LEN    = 5,
  parameter int HIST_DEPTH = 16,
  localparam int POS_W     = $clog2(N*N),
  localparam int CNT_W     = $clog2(N*N+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left,
  input  logic             right,
  input  logic             up,
  input  logic             down,
  input  logic             put,
  input  logic             undo,
  output logic [N*N-1:0]   board_state,
  output logic [N*N-1:0]   turn_map,
  output logic [POS_W-1:0] cursor_pos,
  output logic             side_to_move,
  output logic [CNT_W-1:0] move_count,
  output logic             busy,
  output logic [1:0]       winner,
  output logic             draw
);

  localparam int CELLS = N*N;
  localparam int CTR   = (N-1)/2;
  // Signed row/col width: holds -1 and N so bound checks are plain compares.
  localparam int RC_W  = $clog2(N) + 2;
  localparam int HP_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int HC_W  = $clog2(HIST_DEPTH+1);
  localparam int ST_W  = $clog2(WIN_LEN) + 1;
  localparam int RUN_W = $clog2(WIN_LEN+1) + 1;

  typedef logic signed [RC_W-1:0] rc_t;
  localparam rc_t RC_ONE  = rc_t'(1);
  localparam rc_t RC_LAST = rc_t'(N-1);
  localparam rc_t RC_N    = rc_t'(N);
  localparam rc_t RC_CTR  = rc_t'(CTR);

  typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

  state_t state;

  // Button edge detection
  logic [5:0] btn, prev_btn, rise;
  logic       e_undo, e_put, e_right, e_left, e_up, e_down;

  assign btn     = {undo, put, right, left, up, down};
  assign rise    = btn & ~prev_btn;
  assign e_undo  = rise[5];
  assign e_put   = rise[4];
  assign e_right = rise[3];
  assign e_left  = rise[2];
  assign e_up    = rise[1];
  assign e_down  = rise[0];

  // Cursor and scan registers
  rc_t cur_r, cur_c;
  rc_t place_r, place_c;
  rc_t scan_r, scan_c;
  logic [1:0]       scan_dir;
  logic             scan_neg;
  logic [ST_W-1:0]  scan_step;
  logic [RUN_W-1:0] scan_run;

  // Undo history
  logic [POS_W-1:0] hist [HIST_DEPTH];
  logic [HP_W-1:0]  hist_wr, hist_top, hist_wr_next;
  logic [HC_W-1:0]  hist_cnt;
  logic [POS_W-1:0] undo_idx;

  assign hist_top     = (hist_wr == '0) ? HP_W'(HIST_DEPTH-1) : hist_wr - HP_W'(1);
  assign hist_wr_next = (hist_wr == HP_W'(HIST_DEPTH-1)) ? '0 : hist_wr + HP_W'(1);
  assign undo_idx     = hist[hist_top];

  // Probe cell for the current scan step
  rc_t              dr, dc, probe_r, probe_c;
  logic             probe_in, probe_hit, side_done, win_now;
  logic [POS_W-1:0] probe_idx;
  logic [RUN_W-1:0] run_next;

  // Next neighbour along the active direction/side and its match status
  always_comb begin
    dr = '0;
    dc = '0;
    case (scan_dir)
      2'd0:    dc = RC_ONE;
      2'd1:    dr = RC_ONE;
      2'd2:    begin dr = RC_ONE; dc = RC_ONE;  end
      default: begin dr = RC_ONE; dc = -RC_ONE; end
    endcase
    if (scan_neg) begin
      dr = -dr;
      dc = -dc;
    end
    probe_r   = scan_r + dr;
    probe_c   = scan_c + dc;
    probe_in  = !probe_r[RC_W-1] && (probe_r < RC_N) &&
                !probe_c[RC_W-1] && (probe_c < RC_N);
    probe_idx = POS_W'(int'(probe_r) * N + int'(probe_c));
    probe_hit = probe_in && board_state[probe_idx] &&
                (turn_map[probe_idx] == side_to_move);
    run_next  = scan_run + RUN_W'(1);
    win_now   = probe_hit && (run_next >= RUN_W'(WIN_LEN));
    side_done = !probe_hit || (scan_step == ST_W'(WIN_LEN-2));
  end

  // Previous button levels, sampled every cycle so a button held through
  // reset does not produce an edge when reset is released
  always_ff @(posedge clk) begin
    prev_btn <= btn;
  end

  // Game FSM: actions in IDLE/OVER, sequential win scan in CHECK
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      board_state  <= '0;
      turn_map     <= '0;
      cur_r        <= RC_CTR;
      cur_c        <= RC_CTR;
      cursor_pos   <= POS_W'(CTR*N + CTR);
      side_to_move <= 1'b0;
      move_count   <= '0;
      busy         <= 1'b0;
      winner       <= 2'b00;
      draw         <= 1'b0;
      hist_wr      <= '0;
      hist_cnt     <= '0;
      place_r      <= '0;
      place_c      <= '0;
      scan_r       <= '0;
      scan_c       <= '0;
      scan_dir     <= '0;
      scan_neg     <= 1'b0;
      scan_step    <= '0;
      scan_run     <= '0;
    end else if (state != CHECK) begin
      if (e_undo) begin
        if (hist_cnt != '0) begin
          board_state[undo_idx] <= 1'b0;
          turn_map[undo_idx]    <= 1'b0;
          side_to_move          <= turn_map[undo_idx];
          move_count            <= move_count - CNT_W'(1);
          hist_wr               <= hist_top;
          hist_cnt              <= hist_cnt - HC_W'(1);
          winner                <= 2'b00;
          draw                  <= 1'b0;
          state                 <= IDLE;
        end
      end else if (e_put) begin
        if (state == IDLE && !board_state[cursor_pos]) begin
          board_state[cursor_pos] <= 1'b1;
          turn_map[cursor_pos]    <= side_to_move;
          hist[hist_wr]           <= cursor_pos;
          hist_wr                 <= hist_wr_next;
          if (hist_cnt != HC_W'(HIST_DEPTH))
            hist_cnt <= hist_cnt + HC_W'(1);
          move_count <= move_count + CNT_W'(1);
          place_r    <= cur_r;
          place_c    <= cur_c;
          scan_r     <= cur_r;
          scan_c     <= cur_c;
          scan_dir   <= '0;
          scan_neg   <= 1'b0;
          scan_step  <= '0;
          scan_run   <= RUN_W'(1);
          busy       <= 1'b1;
          state      <= CHECK;
        end
      end else if (e_right) begin
        if (cur_c != RC_LAST) begin
          cur_c      <= cur_c + RC_ONE;
          cursor_pos <= cursor_pos + POS_W'(1);
        end
      end else if (e_left) begin
        if (cur_c != '0) begin
          cur_c      <= cur_c - RC_ONE;
          cursor_pos <= cursor_pos - POS_W'(1);
        end
      end else if (e_up) begin
        if (cur_r != '0) begin
          cur_r      <= cur_r - RC_ONE;
          cursor_pos <= cursor_pos - POS_W'(N);
        end
      end else if (e_down) begin
        if (cur_r != RC_LAST) begin
          cur_r      <= cur_r + RC_ONE;
          cursor_pos <= cursor_pos + POS_W'(N);
        end
      end
    end else begin
      if (win_now) begin
        winner <= side_to_move ? 2'b10 : 2'b01;
        busy   <= 1'b0;
        state  <= OVER;
      end else if (side_done) begin
        if (!scan_neg) begin
          // Positive side finished: rescan from the placed stone backwards,
          // keeping the run collected so far
          scan_neg  <= 1'b1;
          scan_r    <= place_r;
          scan_c    <= place_c;
          scan_step <= '0;
          if (probe_hit)
            scan_run <= run_next;
        end else if (scan_dir != 2'd3) begin
          scan_dir  <= scan_dir + 2'd1;
          scan_neg  <= 1'b0;
          scan_r    <= place_r;
          scan_c    <= place_c;
          scan_step <= '0;
          scan_run  <= RUN_W'(1);
        end else begin
          side_to_move <= ~side_to_move;
          busy         <= 1'b0;
          if (move_count == CNT_W'(CELLS)) begin
            draw  <= 1'b1;
            state <= OVER;
          end else begin
            state <= IDLE;
          end
        end
      end else begin
        scan_r    <= probe_r;
        scan_c    <= probe_c;
        scan_step <= scan_step + ST_W'(1);
        scan_run  <= run_next;
      end
    end
  end

endmodule

// File: tb/tb_gomoku_game_engine.sv
// Self-checking bench for gomoku_game_engine (N=10, WIN_LEN=5, HIST_DEPTH=4).
module tb_gomoku_game_engine;

  localparam int N     = 10;
  localparam int WL    = 5;
  localparam int HD    = 4;
  localparam int POS_W = 7;
  localparam int CNT_W = 7;

  localparam int B_R = 0, B_L = 1, B_U = 2, B_D = 3, B_P = 4, B_Z = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, put = 1'b0, undo = 1'b0;
  logic [N*N-1:0]   board_state, turn_map;
  logic [POS_W-1:0] cursor_pos;
  logic             side_to_move, busy, draw;
  logic [CNT_W-1:0] move_count;
  logic [1:0]       winner;

  gomoku_game_engine #(.N(N), .WIN_LEN(WL), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst(rst),
    .left(left), .right(right), .up(up), .down(down), .put(put), .undo(undo),
    .board_state(board_state), .turn_map(turn_map), .cursor_pos(cursor_pos),
    .side_to_move(side_to_move), .move_count(move_count), .busy(busy),
    .winner(winner), .draw(draw)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mr = 4, mc = 4;

  typedef struct {
    int               btn;
    logic [POS_W-1:0] exp_cursor;
  } vec_t;
  vec_t vecs[$];
  logic [POS_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_R: right = v;
      B_L: left  = v;
      B_U: up    = v;
      B_D: down  = v;
      B_P: put   = v;
      default: undo = v;
    endcase
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mr = 4;
    mc = 4;
  endtask

  // driver: one clean press; outputs are valid when the task returns
  task automatic press(input int b);
    @(negedge clk);
    set_btn(b, 1'b1);
    @(negedge clk);
    set_btn(b, 1'b0);
  endtask

  task automatic goto_cell(input int idx);
    int tr, tc;
    tr = idx / N;
    tc = idx % N;
    while (mc < tc) begin press(B_R); mc++; end
    while (mc > tc) begin press(B_L); mc--; end
    while (mr < tr) begin press(B_D); mr++; end
    while (mr > tr) begin press(B_U); mr--; end
  endtask

  // press put and count the cycles busy stays high afterwards (bounded)
  task automatic do_put(output int cyc);
    press(B_P);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 100) begin
      total++;
      bad++;
      $display("FAIL check_timeout actual=%0d required<%0d", cyc, 100);
    end
  endtask

  task automatic place(input int idx);
    int c;
    goto_cell(idx);
    do_put(c);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_board"},  board_state,  '0);
    check({tag, "_turn"},   turn_map,     '0);
    check({tag, "_cursor"}, cursor_pos,   44);
    check({tag, "_side"},   side_to_move, 0);
    check({tag, "_count"},  move_count,   0);
    check({tag, "_winner"}, winner,       0);
    check({tag, "_draw"},   draw,         0);
    check({tag, "_busy"},   busy,         0);
  endtask

  function automatic void add_vec(input int b, input int exp);
    vec_t v;
    v.btn = b;
    v.exp_cursor = POS_W'(exp);
    vecs.push_back(v);
  endfunction

  initial begin
    int cyc;
    logic [N*N-1:0] exp_board;

    // cursor table: from 44, including every edge of the board
    add_vec(B_R, 45); add_vec(B_R, 46); add_vec(B_L, 45); add_vec(B_U, 35);
    add_vec(B_D, 45); add_vec(B_D, 55);
    for (int i = 0; i < 5; i++) add_vec(B_L, 54 - i);
    add_vec(B_L, 50);
    for (int i = 0; i < 5; i++) add_vec(B_U, 40 - 10*i);
    add_vec(B_U, 0); add_vec(B_L, 0); add_vec(B_D, 10); add_vec(B_R, 11);
    for (int i = 0; i < 8; i++) add_vec(B_R, 12 + i);
    add_vec(B_R, 19);
    for (int i = 0; i < 8; i++) add_vec(B_D, 29 + 10*i);
    add_vec(B_D, 99);

    reset_dut();
    check_reset_values("reset");

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_cursor);
      press(vecs[i].btn);
      check($sformatf("cursor_vec%0d", i), cursor_pos, exp_q.pop_front());
    end

    // four rights then put on an empty board
    reset_dut();
    for (int i = 0; i < 4; i++) begin press(B_R); mc++; end
    check("cursor_48", cursor_pos, 48);
    do_put(cyc);
    check("isolated_check_cycles", cyc, 8);
    exp_board = '0;
    exp_board[48] = 1'b1;
    check("put48_board", board_state, exp_board);
    check("put48_turn", turn_map, '0);
    check("put48_count", move_count, 1);
    check("put48_side", side_to_move, 1);

    // second put on the same cell is ignored
    do_put(cyc);
    check("dup_put_busy_cycles", cyc, 0);
    check("dup_put_count", move_count, 1);
    check("dup_put_side", side_to_move, 1);
    check("dup_put_turn", turn_map, '0);

    // black 40..44 with white 50..53 interleaved
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      place(40 + i);
      place(50 + i);
    end
    check("pre_win_winner", winner, 0);
    check("pre_win_side", side_to_move, 0);
    place(44);
    check("row_win_winner", winner, 2'b01);
    check("row_win_side", side_to_move, 0);
    check("row_win_count", move_count, 9);
    check("row_win_busy", busy, 0);
    place(45);
    check("over_put_count", move_count, 9);
    check("over_put_board45", board_state[45], 0);
    press(B_D);
    mr++;
    check("over_cursor_moves", cursor_pos, 55);

    // undo out of OVER
    press(B_Z);
    check("undo_board44", board_state[44], 0);
    check("undo_winner", winner, 0);
    check("undo_count", move_count, 8);
    check("undo_side", side_to_move, 0);
    check("undo_cursor_kept", cursor_pos, 55);
    place(44);
    check("replay_winner", winner, 2'b01);
    check("replay_count", move_count, 9);

    // history depth 4: six moves, five undos
    reset_dut();
    place(0); place(2); place(4); place(6); place(8); place(20);
    check("six_count", move_count, 6);
    press(B_Z);
    check("undo1_count", move_count, 5);
    check("undo1_side", side_to_move, 1);
    press(B_Z);
    check("undo2_count", move_count, 4);
    check("undo2_side", side_to_move, 0);
    press(B_Z);
    press(B_Z);
    check("undo4_count", move_count, 2);
    check("undo4_side", side_to_move, 0);
    press(B_Z);
    check("undo5_count", move_count, 2);
    exp_board = '0;
    exp_board[0] = 1'b1;
    exp_board[2] = 1'b1;
    check("undo5_board", board_state, exp_board);
    check("undo5_turn", turn_map[2], 1);

    // index-contiguous black 47..51 wraps across rows and must not win
    reset_dut();
    place(47); place(90); place(48); place(92); place(49); place(94);
    place(50); place(96);
    place(51);
    check("wrap_no_winner", winner, 0);
    check("wrap_side", side_to_move, 1);
    check("wrap_count", move_count, 9);
    goto_cell(49);
    press(B_R);
    check("right_edge_cursor", cursor_pos, 49);

    // white anti-diagonal 5,14,23,32,41 completed at the lower end
    place(5);  place(60); place(14); place(62); place(23); place(64);
    place(32); place(66);
    check("anti_pre_winner", winner, 0);
    place(41);
    check("anti_winner", winner, 2'b10);
    check("anti_side", side_to_move, 1);
    check("anti_count", move_count, 18);

    // reset in the middle of a winning CHECK
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      place(40 + i);
      place(50 + i);
    end
    goto_cell(44);
    press(B_P);
    check("mid_check_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mr = 4;
    mc = 4;
    check_reset_values("mid_rst");
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("mid_rst_late_winner", winner, 0);
    check("mid_rst_late_board", board_state, '0);

    // button held through reset release gives no edge
    @(negedge clk);
    rst = 1'b1;
    right = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("held_right_cursor", cursor_pos, 44);
    right = 1'b0;
    press(B_R);
    check("after_hold_right", cursor_pos, 45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
